led_status_arbiter: RTL and testbench

- Shares the board status LEDs (one RGB LED plus a 4-bit LED bar) between NUM_REQ independent status requesters.
- Grants one requester at a time by fixed priority (index 0 highest).
- Enforces a minimum display hold time and generates solid, slow-blink, fast-blink and counted-burst patterns on a millisecond-style tick.
- Outputs are active-high logical LED commands. They feed the existing PWM brightness/LED-polarity driver, so this block performs no PWM or pin inversion.

---
 rtl/led_status_pkg.sv | 34 +++
 rtl/led_tick_gen.sv | 36 +++
 rtl/led_status_arbiter.sv | 219 +++++++++++++++++++++
 tb/tb_led_status_arbiter.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/led_status_pkg.sv
// Shared types and width helpers for the board status LED arbiter.
package led_status_pkg;

    typedef enum logic [1:0] {
        SOLID = 2'd0,
        SLOW  = 2'd1,
        FAST  = 2'd2,
        BURST = 2'd3
    } mode_t;

    typedef enum logic [2:0] {
        IDLE,
        SHOW,
        BURST_ON,
        BURST_OFF,
        DONE
    } state_t;

    typedef struct packed {
        logic r;
        logic g;
        logic b;
    } rgb_t;

    localparam int OWNER_W = 2;
    localparam int COUNT_W = 4;
    localparam int LED_W   = 4;

    // Counter width able to hold 0..max_val; never narrower than one bit.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Free-running prescaler: one-cycle tick every CLK_FREQ/TICK_HZ clock cycles.
module led_tick_gen
    import led_status_pkg::*;
#(
    parameter int CLK_FREQ = 12000000,
    parameter int TICK_HZ  = 1000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick_o
);

    localparam int TERM  = CLK_FREQ / TICK_HZ - 1;
    localparam int CNT_W = cnt_width(TERM);
    localparam logic [CNT_W-1:0] TERM_C = CNT_W'(TERM);

    if (TICK_HZ < 1 || CLK_FREQ < TICK_HZ) begin : g_bad_rate
        $error("led_tick_gen: TICK_HZ must be between 1 and CLK_FREQ");
    end

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        tick_o = (cnt_q == TERM_C);
        cnt_d  = tick_o ? '0 : cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/led_status_arbiter.sv
// Fixed-priority sharing of the status RGB LED and LED bar between requesters,
// with minimum hold time and solid / blink / counted-burst patterns.
module led_status_arbiter
    import led_status_pkg::*;
#(
    parameter int CLK_FREQ        = 12000000,
    parameter int TICK_HZ         = 1000,
    parameter int NUM_REQ         = 4,
    parameter int MIN_HOLD_TICKS  = 250,
    parameter int SLOW_HALF_TICKS = 500,
    parameter int FAST_HALF_TICKS = 100
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid_i,
    input  logic [3*NUM_REQ-1:0] req_color_i,
    input  logic [2*NUM_REQ-1:0] req_mode_i,
    input  logic [4*NUM_REQ-1:0] req_count_i,
    output logic [2:0]           rgb_o,
    output logic [3:0]           led_o,
    output logic                 busy_o,
    output logic [NUM_REQ-1:0]   done_o
);

    localparam int HALF_MAX = (SLOW_HALF_TICKS > FAST_HALF_TICKS) ? SLOW_HALF_TICKS : FAST_HALF_TICKS;
    localparam int HOLD_W   = cnt_width(MIN_HOLD_TICKS);
    localparam int HALF_W   = cnt_width(HALF_MAX);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(MIN_HOLD_TICKS);
    localparam logic [HALF_W-1:0] SLOW_HALF = HALF_W'(SLOW_HALF_TICKS);
    localparam logic [HALF_W-1:0] FAST_HALF = HALF_W'(FAST_HALF_TICKS);

    if (SLOW_HALF_TICKS < 1 || FAST_HALF_TICKS < 1) begin : g_bad_half
        $error("led_status_arbiter: blink half-periods must be non-zero");
    end
    if (NUM_REQ < 2 || NUM_REQ > 4) begin : g_bad_num_req
        $error("led_status_arbiter: NUM_REQ must be 2..4");
    end

    logic tick;

    led_tick_gen #(
        .CLK_FREQ (CLK_FREQ),
        .TICK_HZ  (TICK_HZ)
    ) u_tick_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .tick_o (tick)
    );

    state_t               state_q, state_d;
    logic [OWNER_W-1:0]   owner_q, owner_d;
    rgb_t                 color_q, color_d;
    mode_t                mode_q, mode_d;
    logic [COUNT_W-1:0]   count_q, count_d;
    logic [HOLD_W-1:0]    hold_q, hold_d;
    logic [HALF_W-1:0]    half_q, half_d;
    logic                 phase_q, phase_d;
    logic [NUM_REQ-1:0]   lockout_q, lockout_d;
    rgb_t                 rgb_q, rgb_d;
    logic [LED_W-1:0]     led_q, led_d;
    logic                 busy_q, busy_d;
    logic [NUM_REQ-1:0]   done_q, done_d;

    logic [NUM_REQ-1:0]   owner_mask, arb_vec;
    logic                 any_elig;
    logic [OWNER_W-1:0]   winner;
    logic [COUNT_W-1:0]   win_count;
    logic [HALF_W-1:0]    half_inc, half_lim;
    logic                 grant;

    // While DONE, the finishing owner's lockout is not yet registered, so mask it here.
    always_comb begin
        owner_mask = NUM_REQ'(1) << owner_q;
        arb_vec    = req_valid_i & ~lockout_q;
        if (state_q == DONE) begin
            arb_vec = arb_vec & ~owner_mask;
        end
        any_elig = |arb_vec;
        winner   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (arb_vec[k]) begin
                winner = OWNER_W'(k);
            end
        end
        win_count = req_count_i[COUNT_W*winner +: COUNT_W];
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        color_d   = color_q;
        mode_d    = mode_q;
        count_d   = count_q;
        hold_d    = hold_q;
        half_d    = half_q;
        phase_d   = phase_q;
        lockout_d = lockout_q & req_valid_i;
        done_d    = '0;
        grant     = 1'b0;
        half_inc  = half_q + HALF_W'(1);
        half_lim  = (mode_q == SLOW) ? SLOW_HALF : FAST_HALF;

        case (state_q)
            IDLE: grant = any_elig;
            SHOW: begin
                if (hold_q == HOLD_MAX &&
                    (!req_valid_i[owner_q] || (any_elig && (winner < owner_q)))) begin
                    grant = any_elig;
                    if (!any_elig) begin
                        state_d = IDLE;
                    end
                end else if (tick) begin
                    if (hold_q != HOLD_MAX) begin
                        hold_d = hold_q + HOLD_W'(1);
                    end
                    if (mode_q != SOLID) begin
                        if (half_inc == half_lim) begin
                            half_d  = '0;
                            phase_d = ~phase_q;
                        end else begin
                            half_d = half_inc;
                        end
                    end
                end
            end
            BURST_ON: begin
                if (tick) begin
                    if (half_inc == FAST_HALF) begin
                        half_d  = '0;
                        state_d = BURST_OFF;
                    end else begin
                        half_d = half_inc;
                    end
                end
            end
            BURST_OFF: begin
                if (tick) begin
                    if (half_inc == FAST_HALF) begin
                        half_d = '0;
                        if (count_q <= COUNT_W'(1)) begin
                            state_d = DONE;
                            done_d  = owner_mask;
                        end else begin
                            count_d = count_q - COUNT_W'(1);
                            state_d = BURST_ON;
                        end
                    end else begin
                        half_d = half_inc;
                    end
                end
            end
            DONE: begin
                lockout_d = (lockout_q | owner_mask) & req_valid_i;
                grant     = any_elig;
                if (!any_elig) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A fresh grant restarts every timer, so a coincident tick is not counted.
        if (grant) begin
            owner_d = winner;
            color_d = rgb_t'(req_color_i[3*winner +: 3]);
            mode_d  = mode_t'(req_mode_i[2*winner +: 2]);
            count_d = (win_count == '0) ? COUNT_W'(1) : win_count;
            hold_d  = '0;
            half_d  = '0;
            phase_d = 1'b1;
            state_d = (mode_d == BURST) ? BURST_ON : SHOW;
        end

        rgb_d = '0;
        if (state_d == BURST_ON || (state_d == SHOW && phase_d)) begin
            rgb_d = color_d;
        end
        led_d  = (state_d == IDLE) ? '0 : (LED_W'(1) << owner_d);
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            owner_q   <= '0;
            color_q   <= '0;
            mode_q    <= SOLID;
            count_q   <= '0;
            hold_q    <= '0;
            half_q    <= '0;
            phase_q   <= 1'b0;
            lockout_q <= '0;
            rgb_q     <= '0;
            led_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            color_q   <= color_d;
            mode_q    <= mode_d;
            count_q   <= count_d;
            hold_q    <= hold_d;
            half_q    <= half_d;
            phase_q   <= phase_d;
            lockout_q <= lockout_d;
            rgb_q     <= rgb_d;
            led_q     <= led_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign rgb_o  = rgb_q;
    assign led_o  = led_q;
    assign busy_o = busy_q;
    assign done_o = done_q;

endmodule

// File: tb/tb_led_status_arbiter.sv
// Directed bench for led_status_arbiter: tick every 10 cycles, hold 3, slow 4, fast 2.
// Expected outputs are queued as each step is driven and popped once the DUT responds.
module tb_led_status_arbiter;

    localparam int NUM_REQ = 4;
    localparam logic [1:0] M_SOLID = 2'd0;
    localparam logic [1:0] M_SLOW  = 2'd1;
    localparam logic [1:0] M_FAST  = 2'd2;
    localparam logic [1:0] M_BURST = 2'd3;
    localparam logic [11:0] FULL      = 12'hFFF;
    localparam logic [11:0] RGB_DONE  = 12'hE0F;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NUM_REQ-1:0]   req_valid;
    logic [3*NUM_REQ-1:0] req_color;
    logic [2*NUM_REQ-1:0] req_mode;
    logic [4*NUM_REQ-1:0] req_count;
    logic [2:0]           rgb_o;
    logic [3:0]           led_o;
    logic                 busy_o;
    logic [NUM_REQ-1:0]   done_o;

    led_status_arbiter #(
        .CLK_FREQ        (1000),
        .TICK_HZ         (100),
        .NUM_REQ         (NUM_REQ),
        .MIN_HOLD_TICKS  (3),
        .SLOW_HALF_TICKS (4),
        .FAST_HALF_TICKS (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid_i (req_valid),
        .req_color_i (req_color),
        .req_mode_i  (req_mode),
        .req_count_i (req_count),
        .rgb_o       (rgb_o),
        .led_o       (led_o),
        .busy_o      (busy_o),
        .done_o      (done_o)
    );

    always #5 clk = ~clk;

    // Edges since reset release; ticks are consumed on edges where cyc becomes a multiple of 10.
    int cyc = 0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    int done0_cnt = 0;
    always @(negedge clk) begin
        if (done_o[0] === 1'b1) done0_cnt <= done0_cnt + 1;
    end

    typedef struct {
        string       tag;
        logic [11:0] val;
        logic [11:0] mask;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic sync_to(input int ph);
        for (int i = 0; i < 10; i++) begin
            if (cyc % 10 == ph) break;
            step(1);
        end
    endtask

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic [2:0] rgb, input logic [3:0] led,
                              input logic busy, input logic [3:0] done, input logic [11:0] mask);
        exp_t e;
        e.tag  = tag;
        e.val  = {rgb, led, busy, done};
        e.mask = mask;
        sb_q.push_back(e);
    endtask

    task automatic check_output();
        exp_t        e;
        logic [11:0] obs;
        obs = {rgb_o, led_o, busy_o, done_o};
        if (sb_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $error("[TB] FAIL scoreboard_empty: observed=0x%0h expected=entry", obs);
        end else begin
            e = sb_q.pop_front();
            check_value(e.tag, {20'd0, obs & e.mask}, {20'd0, e.val & e.mask});
        end
    endtask

    task automatic after_steps(input int n, input string tag, input logic [2:0] rgb,
                               input logic [3:0] led, input logic busy, input logic [3:0] done,
                               input logic [11:0] mask);
        expect_out(tag, rgb, led, busy, done, mask);
        step(n);
        check_output();
    endtask

    task automatic apply_stimulus(input int idx, input logic valid, input logic [2:0] color,
                                  input logic [1:0] mode, input logic [3:0] count);
        req_valid[idx]         = valid;
        req_color[3*idx +: 3]  = color;
        req_mode[2*idx +: 2]   = mode;
        req_count[4*idx +: 4]  = count;
    endtask

    task automatic drop(input int idx);
        req_valid[idx] = 1'b0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] simulation time limit exceeded");
    end

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_color = '0;
        req_mode  = '0;
        req_count = '0;
        step(2);
        after_steps(0, "reset_idle", 3'b000, 4'b0000, 1'b0, 4'b0000, FULL);
        rst_n = 1'b1;

        // Solid grant, steady display, release to idle.
        step(4);
        apply_stimulus(2, 1'b1, 3'b010, M_SOLID, 4'd0);
        after_steps(1,  "solid_grant",   3'b010, 4'b0100, 1'b1, 4'b0000, FULL);
        after_steps(94, "solid_steady",  3'b010, 4'b0100, 1'b1, 4'b0000, FULL);
        drop(2);
        after_steps(1,  "solid_release", 3'b000, 4'b0000, 1'b0, 4'b0000, FULL);

        // Slow blink granted on a tick edge: that tick must not count.
        sync_to(9);
        apply_stimulus(3, 1'b1, 3'b111, M_SLOW, 4'd0);
        after_steps(1,  "slow_grant_on",  3'b111, 4'b1000, 1'b1, 4'b0000, FULL);
        after_steps(39, "slow_on_end",    3'b111, 4'b1000, 1'b1, 4'b0000, FULL);
        after_steps(1,  "slow_off",       3'b000, 4'b1000, 1'b1, 4'b0000, FULL);
        after_steps(39, "slow_off_end",   3'b000, 4'b1000, 1'b1, 4'b0000, FULL);
        after_steps(1,  "slow_on_again",  3'b111, 4'b1000, 1'b1, 4'b0000, FULL);
        drop(3);
        after_steps(1,  "slow_release",   3'b000, 4'b0000, 1'b0, 4'b0000, FULL);

        // Hold time blocks preemption; afterwards preemption, regrant and immediate switch.
        sync_to(0);
        apply_stimulus(3, 1'b1, 3'b001, M_SOLID, 4'd0);
        after_steps(1,  "hold_grant3",         3'b001, 4'b1000, 1'b1, 4'b0000, FULL);
        step(11);
        apply_stimulus(1, 1'b1, 3'b110, M_FAST, 4'd0);
        after_steps(18, "hold_blocks_preempt", 3'b001, 4'b1000, 1'b1, 4'b0000, FULL);
        after_steps(1,  "preempt_after_hold",  3'b110, 4'b0010, 1'b1, 4'b0000, FULL);
        after_steps(18, "fast_on_end",         3'b110, 4'b0010, 1'b1, 4'b0000, FULL);
        after_steps(1,  "fast_off_low_waits",  3'b000, 4'b0010, 1'b1, 4'b0000, FULL);
        step(11);
        drop(1);
        after_steps(1,  "owner_drop_regrant",  3'b001, 4'b1000, 1'b1, 4'b0000, FULL);
        after_steps(33, "hold_before_raise",   3'b001, 4'b1000, 1'b1, 4'b0000, FULL);
        apply_stimulus(1, 1'b1, 3'b110, M_FAST, 4'd0);
        after_steps(1,  "preempt_immediate",   3'b110, 4'b0010, 1'b1, 4'b0000, FULL);
        step(34);
        drop(1);
        drop(3);
        after_steps(1,  "show_release_idle",   3'b000, 4'b0000, 1'b0, 4'b0000, FULL);

        // Three-pulse burst, ignored competitor, done pulse, lockout, direct grant.
        sync_to(0);
        apply_stimulus(0, 1'b1, 3'b100, M_BURST, 4'd3);
        after_steps(1,  "burst_on1",      3'b100, 4'b0001, 1'b1, 4'b0000, FULL);
        after_steps(18, "burst_on1_end",  3'b100, 4'b0001, 1'b1, 4'b0000, FULL);
        after_steps(1,  "burst_off1",     3'b000, 4'b0001, 1'b1, 4'b0000, FULL);
        step(10);
        apply_stimulus(1, 1'b1, 3'b010, M_SOLID, 4'd0);
        after_steps(9,  "burst_off1_end", 3'b000, 4'b0001, 1'b1, 4'b0000, FULL);
        after_steps(1,  "burst_on2",      3'b100, 4'b0001, 1'b1, 4'b0000, FULL);
        after_steps(59, "burst_on3_end",  3'b100, 4'b0001, 1'b1, 4'b0000, FULL);
        after_steps(1,  "burst_off3",     3'b000, 4'b0001, 1'b1, 4'b0000, FULL);
        after_steps(19, "burst_off3_end", 3'b000, 4'b0001, 1'b1, 4'b0000, FULL);
        after_steps(1,  "burst_done",     3'b000, 4'b0000, 1'b0, 4'b0001, RGB_DONE);
        after_steps(1,  "done_direct_grant", 3'b010, 4'b0010, 1'b1, 4'b0000, FULL);
        check_value("done0_pulses_burst3", done0_cnt, 32'd1);
        step(34);
        drop(1);
        after_steps(1,  "locked_out_idle",      3'b000, 4'b0000, 1'b0, 4'b0000, FULL);
        step(4);
        drop(0);
        after_steps(1,  "lockout_cleared_idle", 3'b000, 4'b0000, 1'b0, 4'b0000, FULL);

        // Burst count 0 behaves as a single pulse.
        sync_to(0);
        apply_stimulus(0, 1'b1, 3'b001, M_BURST, 4'd0);
        after_steps(1,  "burst0_on",      3'b001, 4'b0001, 1'b1, 4'b0000, FULL);
        after_steps(19, "burst0_off",     3'b000, 4'b0001, 1'b1, 4'b0000, FULL);
        after_steps(19, "burst0_off_end", 3'b000, 4'b0001, 1'b1, 4'b0000, FULL);
        after_steps(1,  "burst0_done",    3'b000, 4'b0000, 1'b0, 4'b0001, RGB_DONE);
        after_steps(1,  "burst0_idle",    3'b000, 4'b0000, 1'b0, 4'b0000, FULL);
        check_value("done0_pulses_burst0", done0_cnt, 32'd2);
        drop(0);
        step(1);

        // Asynchronous reset mid-burst, then a fresh regrant of the pending request.
        sync_to(0);
        apply_stimulus(0, 1'b1, 3'b100, M_BURST, 4'd2);
        after_steps(1, "rst_test_on", 3'b100, 4'b0001, 1'b1, 4'b0000, FULL);
        step(4);
        rst_n = 1'b0;
        #1;
        expect_out("async_reset", 3'b000, 4'b0000, 1'b0, 4'b0000, FULL);
        check_output();
        step(2);
        rst_n = 1'b1;
        after_steps(1,  "regrant_after_reset", 3'b100, 4'b0001, 1'b1, 4'b0000, FULL);
        after_steps(18, "fresh_phase_on",      3'b100, 4'b0001, 1'b1, 4'b0000, FULL);
        after_steps(1,  "fresh_phase_off",     3'b000, 4'b0001, 1'b1, 4'b0000, FULL);
        check_value("no_done_on_reset", done0_cnt, 32'd2);
        drop(0);
        step(2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
